// File: rtl/mul_arb_pkg.sv
// Shared constants and tag type for the shared signed multiplier arbiter.
//   MUL_A_W/MUL_B_W/MUL_P_W : operand and truncated product widths
//   MUL_LAT                 : multiplier pipeline depth (stages 1..2)
//   tag_t                   : {valid, requester id} carried beside the operands
package mul_arb_pkg;

  localparam int unsigned MUL_A_W  = 6;
  localparam int unsigned MUL_B_W  = 16;
  localparam int unsigned MUL_P_W  = 21;
  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned FLIGHT_W = $clog2(MUL_LAT + 1);

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_s6_s16_pipe.sv
// Two-stage signed 6x16 multiplier: registered operands, then registered
// product truncated to 21 bits. No reset; advances only when ce is high.
//   clk : clock
//   ce  : clock enable for both stages
//   a   : signed 6-bit operand
//   b   : signed 16-bit operand
//   p   : signed 21-bit product (two's-complement wrap)
module mul_s6_s16_pipe
  import mul_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      ce,
  input  logic signed [MUL_A_W-1:0] a,
  input  logic signed [MUL_B_W-1:0] b,
  output logic signed [MUL_P_W-1:0] p
);

  localparam int unsigned FULL_W = MUL_A_W + MUL_B_W;

  logic signed [MUL_A_W-1:0] r_a;
  logic signed [MUL_B_W-1:0] r_b;
  logic signed [MUL_P_W-1:0] r_p;
  logic signed [FULL_W-1:0]  w_a_ext;
  logic signed [FULL_W-1:0]  w_b_ext;
  logic signed [FULL_W-1:0]  w_full;

  // Sign-extend both operands to the full product width before multiplying.
  assign w_a_ext = FULL_W'(r_a);
  assign w_b_ext = FULL_W'(r_b);
  assign w_full  = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    if (ce) begin
      r_a <= a;
      r_b <= b;
      r_p <= MUL_P_W'(w_full);
    end
  end

  assign p = r_p;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ
// requesters; a tag pipeline returns the requester id with each product.
// Output backpressure freezes the whole pipeline through one clock enable.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_valid    : per-requester operand valid
//   req_ready    : per-requester accept (one-hot or zero)
//   req_a, req_b : packed signed operands, requester i at slice i
//   res_valid    : result valid       res_ready : downstream accept
//   res_id       : issuing requester  res_data  : signed 21-bit product
//   in_flight    : valid operations held in stages 1..2
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*MUL_A_W-1:0]   req_a,
  input  logic [NUM_REQ*MUL_B_W-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_W-1:0]              res_id,
  output logic signed [MUL_P_W-1:0]    res_data,
  output logic [FLIGHT_W-1:0]          in_flight
);

  tag_t                      r_s1;
  tag_t                      r_s2;
  logic [ID_W-1:0]           r_rr_ptr;
  logic [FLIGHT_W-1:0]       r_in_flight;

  logic                      w_ce;
  logic                      w_gnt_found;
  logic [ID_W-1:0]           w_gnt_id;
  logic [ID_W-1:0]           w_ptr_next;
  logic                      w_xfer;
  int unsigned               w_idx;
  logic signed [MUL_A_W-1:0] w_sel_a;
  logic signed [MUL_B_W-1:0] w_sel_b;

  // Pipeline advances unless a held result is being refused downstream.
  assign w_ce = ~(r_s2.valid & ~res_ready);

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_gnt_found && req_valid[ID_W'(w_idx)]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = ID_W'(w_idx);
      end
    end
  end

  // Reset gating keeps ready low while reset is asserted, even with requests up.
  assign req_ready = (w_gnt_found && w_ce && reset_n) ? (NUM_REQ'(1) << w_gnt_id) : '0;
  assign w_xfer    = w_gnt_found & w_ce;

  assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  assign w_sel_a = req_a[w_gnt_id*MUL_A_W +: MUL_A_W];
  assign w_sel_b = req_b[w_gnt_id*MUL_B_W +: MUL_B_W];

  // Tag/valid pipeline and round-robin pointer, frozen while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_rr_ptr    <= '0;
      r_in_flight <= '0;
    end else if (w_ce) begin
      r_s1        <= '{valid: w_xfer, id: TAG_ID_W'(w_gnt_id)};
      r_s2        <= r_s1;
      r_in_flight <= FLIGHT_W'(w_xfer) + FLIGHT_W'(r_s1.valid);
      if (w_xfer) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  mul_s6_s16_pipe u_mul (
    .clk (clk),
    .ce  (w_ce),
    .a   (w_sel_a),
    .b   (w_sel_b),
    .p   (res_data)
  );

  assign res_valid = r_s2.valid;
  assign res_id    = ID_W'(r_s2.id);
  assign in_flight = r_in_flight;

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined signed multiplier (6-bit signed x 16-bit signed -> 21-bit signed, 2-cycle latency) among NUM_REQ requesters.
- Round-robin arbitration on the issue side; a tag pipeline carries the requester ID alongside the operands.
- Results return on one valid/ready channel. Output backpressure stalls the whole pipeline through the multiplier clock enable.
- Sits between parallel layer-compute engines and a single DSP slice, which saves DSP48 resources.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*6  packed signed 6-bit operands; requester i uses bits [6i+5:6i].
- req_b  in  NUM_REQ*16  packed signed 16-bit operands.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_id  out  ID_W  requester that issued this result.
- res_data  out  21  signed product.
- in_flight  out  2  number of valid operations in stages 1..2 (0..2).

Behaviour:
- Reset values: req_ready=0, res_valid=0, res_id=0, in_flight=0, rr_ptr=0, all stage valid bits 0. The multiplier datapath registers are not reset; res_data is don't-care while res_valid=0.
- Stall rule: ce = ~(res_valid & ~res_ready). ce drives the multiplier and every tag/valid stage.
- Grant: combinational round-robin.
  - Search starts at rr_ptr and picks the first i (mod NUM_REQ) with req_valid[i]=1.
  - req_ready[i] = grant[i] & ce.
  - A transfer occurs when req_valid[i] & req_ready[i].
- rr_ptr: on a transfer, rr_ptr <= (i+1) mod NUM_REQ. It holds when there is no transfer or the pipeline is stalled.
- Pipeline, advancing only when ce=1:
  - Stage 1 registers operands, v1 and id1.
  - Stage 2 registers the product, v2 and id2.
  - res_valid = v2, res_id = id2, res_data = product register.
- Latency: a transfer at edge t gives res_valid=1 after edge t+2 if no stall intervenes. Throughput is one result per cycle.
- Stall: while res_valid=1 and res_ready=0, all stages, outputs and rr_ptr hold. No requester gets ready and res_data stays stable.
- Bubbles: if no requester is valid while ce=1, a bubble (v=0) enters stage 1.
- res_valid=1 with res_ready=1 in the same cycle as a new transfer: both complete, pipeline advances.
- Arithmetic: full signed product truncated to 21 bits, two's-complement wrap. The only overflow case is (-32)*(-32768) = +1048576, which wraps to -1048576 (0x100000).
- in_flight = v1 + v2, registered along with the stages.
- Requester rules:
  - A requester must hold req_a/req_b stable while req_valid=1 and not accepted.
  - Dropping req_valid before acceptance is allowed; the arbiter must not grant on a stale request.
- Reset mid-operation: in-flight results are discarded, valid bits clear immediately (asynchronously) and rr_ptr returns to 0. No result emerges after reset deasserts unless a new transfer occurs.

Decomposition:
- Shared package mul_arb_pkg:
  - MUL_A_W=6, MUL_B_W=16, MUL_P_W=21, MUL_LAT=2.
  - Typedef for the {valid, id} tag.
- One sub-module, mul_s6_s16_pipe: clk, ce, a, b, p; registered inputs plus registered product, no reset.
- The arbiter, rr_ptr and tag pipeline live in mul_share_arb.

Test Plan:
- Single op: req 0 sends a=-3, b=1000 at edge 0, res_ready=1 -> at edge 2 res_valid=1, res_id=0, res_data=-3000; in_flight is 1,1,0.
- Round-robin: all 4 requesters valid continuously, res_ready=1 -> grants go 0,1,2,3,0..., one per cycle, and results return in the same order 2 cycles later.
- Boundary math:
  - 31*32767 -> 1015777.
  - -32*32767 -> -1048544.
  - (-32)*(-32768) -> wraps to -1048576.
- Backpressure: hold res_ready=0 for 5 cycles while the pipeline is full -> res_data/res_id stable, req_ready all 0, rr_ptr frozen; on release, no results are lost or duplicated.
- Sparse traffic: only requester 2 valid for 10 cycles, then requester 1 -> requester 2 gets every grant, and requester 1 is granted next cycle it asserts (pointer at 3, wraps to 1).
- Reset mid-flight: assert reset_n=0 with 2 ops in flight -> res_valid, req_ready and in_flight go 0 asynchronously; after release no stale result appears.
